cache_ctrl: RTL and testbench
=============================

CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 Parameter ADDR_W, default 10, word address width (1024-word main memory).
REQ-002 Parameter INDEX_W, default 5, cache line index width (32 lines).
REQ-003 Parameter OFFSET_W, default 2, word-in-block width (4-word blocks); TAG_W = ADDR_W-INDEX_W-OFFSET_W (3).
REQ-004 CLK  in  1  single clock; all state updates on the rising edge.
REQ-005 RST  in  1  reset, synchronous, active-low.
REQ-006 MemReadCpu  in  1  load request from the control unit's main decoder.
REQ-007 MemWriteCpu  in  1  store request from the control unit's main decoder.
REQ-008 CpuAddr  in  ADDR_W  word address from the ALU result.
REQ-009 Stall  out  1  freezes PC and register-file write while high.
REQ-010 Hit  out  1  tag match with valid line at CpuAddr's index (combinational).
REQ-011 CacheWE  out  1  data-array write strobe.
REQ-012 CacheFill  out  1  data-array write source: 1 = memory data, 0 = CPU store data.
REQ-013 CacheWordSel  out  OFFSET_W  data-array word offset for the write.
REQ-014 MemRead  out  1  main-memory word read request.
REQ-015 MemWrite  out  1  main-memory word write request.
REQ-016 MemAddr  out  ADDR_W  main-memory word address.
REQ-017 MemAck  in  1  one-cycle pulse: memory completed the current word.

Function
REQ-018 Policy SHALL be direct-mapped, write-through, no-write-allocate; CpuAddr split {tag, index, offset} MSB to LSB.
REQ-019 FSM states SHALL be IDLE, REFILL, WRITE, WDONE.
REQ-020 IDLE, MemReadCpu and Hit: Stall=0, no memory traffic, remain IDLE (zero-latency hit).
REQ-021 IDLE, MemReadCpu and not Hit: Stall=1 in the same cycle, latch {tag,index}, word counter=0, next state REFILL.
REQ-022 REFILL: Stall=1, MemRead=1, MemAddr={latched tag, latched index, counter}; on MemAck: CacheWE=1, CacheFill=1, CacheWordSel=counter, counter increments.
REQ-023 REFILL, MemAck with counter=3: write latched tag, set valid bit, counter wraps to 0, next state IDLE; the request still held by the CPU then hits with Stall=0.
REQ-024 IDLE, MemWriteCpu: Stall=1, latch CpuAddr, next state WRITE; MemWriteCpu has priority if both requests are high.
REQ-025 WRITE: Stall=1, MemWrite=1, MemAddr=latched address; on MemAck: if Hit on latched address, CacheWE=1, CacheFill=0, CacheWordSel=latched offset; next state WDONE.
REQ-026 Write miss SHALL NOT modify tag, valid or data arrays.
REQ-027 WDONE: Stall=0 for exactly one cycle, no memory traffic, next state IDLE unconditionally.
REQ-028 MemAck in IDLE or WDONE SHALL be ignored.
REQ-029 CacheWE, MemRead and MemWrite SHALL be 0 in every case not listed above.
REQ-030 A refill evicts the old line at that index with no write-back (memory already current).

Reset
REQ-031 RST low at a clock edge: state=IDLE, counter=0, all 32 valid bits=0; tags need no reset.
REQ-032 Outputs during and after reset: Stall=0 unless a request is present, Hit=0, CacheWE=MemRead=MemWrite=0.
REQ-033 Reset mid-REFILL SHALL leave the partially filled line invalid; reset mid-WRITE abandons the store.

Structure
REQ-034 Package cache_pkg SHALL hold ADDR_W, INDEX_W, OFFSET_W, TAG_W defaults and the FSM state enumeration.
REQ-035 One sub-module tag_valid_store (tag and valid arrays, synchronous write, combinational read and compare) SHALL be instantiated; the data array stays outside this block.

Verification
REQ-036 Cold read at 0x040 -> Stall=1; MemAddr 0x040,0x041,0x042,0x043 with four CacheWE fills; then Hit=1, Stall=0.
REQ-037 Read 0x042 after REQ-036 -> Hit=1, Stall=0 in the first cycle, MemRead never asserted.
REQ-038 Store to 0x041 (hit) -> MemWrite with MemAddr=0x041 until MemAck; CacheWE=1, CacheFill=0, CacheWordSel=1 on the ack; WDONE one cycle with Stall=0.
REQ-039 Store to 0x3C0 (miss) -> memory write only, no CacheWE; following read of 0x3C0 misses.
REQ-040 Read 0x140 (same index as 0x040, different tag) -> refill evicts; subsequent read of 0x040 misses.
REQ-041 RST low after the second MemAck of a refill at 0x080 -> state IDLE, read of 0x080 misses and refills from word 0.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: shared cache geometry defaults and controller state encoding
package cache_pkg;
  localparam int ADDR_W = 10;
  localparam int INDEX_W = 5;
  localparam int OFFSET_W = 2;
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  typedef enum logic [1:0] {IDLE, REFILL, WRITE, WDONE} state_t;
endpackage

// File: rtl/tag_valid_store.sv
// tag_valid_store: per-line tag and valid arrays with one write port and a combinational lookup
module tag_valid_store #(
  parameter int INDEX_W = cache_pkg::INDEX_W,
  parameter int TAG_W = cache_pkg::TAG_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INDEX_W-1:0] rd_idx,
  input  logic [TAG_W-1:0]   rd_tag,
  output logic               hit,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic               wr_valid
);
  localparam int LINES = 1 << INDEX_W;
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tags [LINES];
  assign hit = valid[rd_idx] && tags[rd_idx] == rd_tag;
  // valid bits clear on reset; a write either invalidates or validates one line
  always_ff @(posedge clk)
    if (!rst_n) valid <= '0;
    else if (wr_en) valid[wr_idx] <= wr_valid;
  // tags carry no reset: they are meaningless until their valid bit is set
  always_ff @(posedge clk)
    if (wr_en) tags[wr_idx] <= wr_tag;
endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: direct-mapped write-through no-write-allocate cache controller
module cache_ctrl #(
  parameter int ADDR_W = cache_pkg::ADDR_W,
  parameter int INDEX_W = cache_pkg::INDEX_W,
  parameter int OFFSET_W = cache_pkg::OFFSET_W
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                MemReadCpu,
  input  logic                MemWriteCpu,
  input  logic [ADDR_W-1:0]   CpuAddr,
  output logic                Stall,
  output logic                Hit,
  output logic                CacheWE,
  output logic                CacheFill,
  output logic [OFFSET_W-1:0] CacheWordSel,
  output logic                MemRead,
  output logic                MemWrite,
  output logic [ADDR_W-1:0]   MemAddr,
  input  logic                MemAck
);
  import cache_pkg::*;
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  state_t state, cur;
  logic [ADDR_W-1:0] lat;
  logic [OFFSET_W-1:0] cnt;
  logic lat_hit, hit_raw, miss, wr_en, wr_valid;
  logic [INDEX_W-1:0] wr_idx;
  tag_valid_store #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_store (
    .clk(CLK),
    .rst_n(RST),
    .rd_idx(CpuAddr[OFFSET_W +: INDEX_W]),
    .rd_tag(CpuAddr[ADDR_W-1 -: TAG_W]),
    .hit(hit_raw),
    .wr_en(wr_en),
    .wr_idx(wr_idx),
    .wr_tag(lat[ADDR_W-1 -: TAG_W]),
    .wr_valid(wr_valid)
  );
  assign Hit = RST & hit_raw;
  // while reset is held the controller behaves as idle with nothing cached
  always_comb begin
    cur = RST ? state : IDLE;
    Stall = cur == IDLE ? (MemWriteCpu | (MemReadCpu & ~Hit)) : cur != WDONE;
    MemRead = cur == REFILL;
    MemWrite = cur == WRITE;
    CacheFill = cur == REFILL;
    CacheWE = MemAck & (cur == REFILL | (cur == WRITE & lat_hit));
    CacheWordSel = cur == REFILL ? cnt : lat[OFFSET_W-1:0];
    MemAddr = cur == REFILL ? {lat[ADDR_W-1:OFFSET_W], cnt} : lat;
    miss = cur == IDLE & MemReadCpu & ~MemWriteCpu & ~Hit;
    wr_en = miss | (cur == REFILL & MemAck & &cnt);
    wr_idx = miss ? CpuAddr[OFFSET_W +: INDEX_W] : lat[OFFSET_W +: INDEX_W];
    wr_valid = ~miss;
  end
  // sequencing of refills and write-through stores; the victim line is invalidated when its refill starts
  always_ff @(posedge CLK)
    if (!RST) begin
      state <= IDLE;
      cnt <= '0;
    end else
      case (state)
        IDLE:
          if (MemWriteCpu) begin
            lat <= CpuAddr;
            lat_hit <= Hit;
            state <= WRITE;
          end else if (MemReadCpu && !Hit) begin
            lat <= CpuAddr;
            cnt <= '0;
            state <= REFILL;
          end
        REFILL:
          if (MemAck) begin
            cnt <= cnt + 1'b1;
            state <= &cnt ? IDLE : REFILL;
          end
        WRITE: state <= MemAck ? WDONE : WRITE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed and randomized transactions checked against a line-level cache model
module tb_cache_ctrl;
  logic CLK = 0, RST = 0, MemReadCpu = 0, MemWriteCpu = 0, MemAck = 0;
  logic [9:0] CpuAddr = '0;
  logic Stall, Hit, CacheWE, CacheFill, MemRead, MemWrite;
  logic [1:0] CacheWordSel;
  logic [9:0] MemAddr;
  int total = 0, bad = 0;
  bit mv [32];
  logic [2:0] mt [32];

  cache_ctrl dut (
    .CLK(CLK), .RST(RST), .MemReadCpu(MemReadCpu), .MemWriteCpu(MemWriteCpu),
    .CpuAddr(CpuAddr), .Stall(Stall), .Hit(Hit), .CacheWE(CacheWE),
    .CacheFill(CacheFill), .CacheWordSel(CacheWordSel), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemAddr(MemAddr), .MemAck(MemAck)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic model_hit(input logic [9:0] a);
    return mv[a[6:2]] && mt[a[6:2]] == a[9:7];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) begin
      mv[i] = 0;
      mt[i] = '0;
    end
  endtask

  task automatic do_read(input logic [9:0] a);
    logic h;
    h = model_hit(a);
    CpuAddr = a;
    MemReadCpu = 1;
    MemWriteCpu = 0;
    @(negedge CLK);
    check("rd_hit", Hit, h);
    check("rd_stall", Stall, !h);
    check("rd_no_mem", {CacheWE, MemRead, MemWrite}, 0);
    if (!h) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        for (int w = $urandom_range(0, 2); w > 0; w--) begin
          @(negedge CLK);
          check("rf_wait", {Stall, MemRead, CacheWE, MemWrite}, 4'b1100);
          check("rf_wait_addr", MemAddr, {a[9:2], 2'(k)});
          tick();
        end
        MemAck = 1;
        @(negedge CLK);
        check("rf_ack", {Stall, MemRead, CacheWE, CacheFill, MemWrite}, 5'b11110);
        check("rf_addr", MemAddr, {a[9:2], 2'(k)});
        check("rf_sel", CacheWordSel, k);
        tick();
        MemAck = 0;
      end
      mv[a[6:2]] = 1;
      mt[a[6:2]] = a[9:7];
      @(negedge CLK);
      check("rf_done", {Hit, Stall, MemRead}, 3'b100);
    end
    tick();
    MemReadCpu = 0;
  endtask

  task automatic do_write(input logic [9:0] a, input logic both);
    logic h;
    h = model_hit(a);
    CpuAddr = a;
    MemWriteCpu = 1;
    MemReadCpu = both;
    @(negedge CLK);
    check("wr_accept", {Stall, MemRead, MemWrite, CacheWE}, 4'b1000);
    tick();
    for (int w = $urandom_range(0, 2); w > 0; w--) begin
      @(negedge CLK);
      check("wr_wait", {Stall, MemWrite, MemRead, CacheWE}, 4'b1100);
      check("wr_wait_addr", MemAddr, a);
      tick();
    end
    MemAck = 1;
    @(negedge CLK);
    check("wr_ack", {Stall, MemWrite, MemRead, CacheWE}, {3'b110, h});
    check("wr_addr", MemAddr, a);
    check("wr_fill", CacheFill, 0);
    if (h) check("wr_sel", CacheWordSel, a[1:0]);
    tick();
    MemAck = 1'($urandom_range(0, 1));
    @(negedge CLK);
    check("wdone", {Stall, MemRead, MemWrite, CacheWE}, 0);
    tick();
    MemAck = 0;
    MemWriteCpu = 0;
    MemReadCpu = 0;
  endtask

  task automatic idle_cycle();
    MemAck = 1'($urandom_range(0, 1));
    @(negedge CLK);
    check("idle", {Stall, CacheWE, MemRead, MemWrite}, 0);
    tick();
    MemAck = 0;
  endtask

  initial begin
    clear_model();
    @(negedge CLK);
    check("rst_out", {Stall, Hit, CacheWE, MemRead, MemWrite}, 0);
    tick();
    tick();
    RST = 1;
    do_read(10'h040);
    do_read(10'h042);
    do_write(10'h041, 0);
    do_write(10'h3C0, 0);
    do_read(10'h3C0);
    do_read(10'h140);
    do_read(10'h040);
    idle_cycle();
    CpuAddr = 10'h080;
    MemReadCpu = 1;
    @(negedge CLK);
    check("abort_miss", {Hit, Stall}, 2'b01);
    tick();
    MemAck = 1;
    tick();
    tick();
    MemAck = 0;
    RST = 0;
    @(negedge CLK);
    check("rst_mid_refill", {Hit, Stall, CacheWE, MemRead, MemWrite}, 5'b01000);
    tick();
    RST = 1;
    MemReadCpu = 0;
    clear_model();
    do_read(10'h080);
    do_read(10'h040);
    for (int n = 0; n < 150; n++) begin
      logic [9:0] a;
      int op;
      a = {3'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 2'($urandom)};
      op = $urandom_range(0, 9);
      if (op < 6) do_read(a);
      else if (op < 9) do_write(a, 1'($urandom_range(0, 1)));
      else idle_cycle();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
